// File: rtl/apb_dummy_pkg.sv
// Shared register map, control/status bit positions and wait-FSM states
// for the APB dummy register file.
package apb_dummy_pkg;

  localparam int unsigned DATA_W = 32;

  // Byte offsets within the 4KB slot
  localparam int unsigned OFS_SIGNATURE    = 32'h00;
  localparam int unsigned OFS_WR_COUNT     = 32'h04;
  localparam int unsigned OFS_CTRL         = 32'h08;
  localparam int unsigned OFS_STATUS       = 32'h0C;
  localparam int unsigned OFS_SCRATCH_BASE = 32'h10;

  localparam int unsigned CTRL_CLR_BIT    = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT = 1;
  localparam int unsigned STATUS_PEND_BIT = 0;
  localparam int unsigned STATUS_IDX_LSB  = 4;
  localparam int unsigned STATUS_IDX_W    = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } wait_state_e;

endpackage

// File: rtl/apb_dummy_regfile_wait_gen.sv
// Wait-state generator: counts access-phase cycles and raises ready once
// WAIT_CYCLES wait states have elapsed.
module apb_wait_gen
  import apb_dummy_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic PSEL,
  input  logic PENABLE,
  output logic ready
);

  localparam int unsigned CNT_W = (WAIT_CYCLES == 0) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

  wait_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              active;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The count is 0 in the first access cycle, so the IDLE cycle is also counted
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    active  = PSEL & PENABLE;
    ready   = HRESETn & active & (cnt_q == CNT_LAST);
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (active && !ready) begin
          state_d = ACCESS;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ACCESS: begin
        if (!active || ready) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/apb_dummy_regfile.sv
// APB dummy slave: signature, write counter, control/status, scratch words,
// configurable wait states, PSLVERR on illegal accesses and a level interrupt.
module apb_dummy_regfile
  import apb_dummy_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned NUM_SCRATCH    = 4,
  parameter int unsigned WAIT_CYCLES    = 2,
  parameter logic [31:0] SIGNATURE      = 32'hC0DE_0001
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic                      irq_o
);

  localparam int unsigned IDX_W     = APB_ADDR_WIDTH - 2;
  localparam int unsigned SCR_FIRST = OFS_SCRATCH_BASE >> 2;

  logic                    ready;
  logic [IDX_W-1:0]        widx;
  logic                    hit_sig, hit_cnt, hit_ctrl, hit_status, hit_scr;
  logic [STATUS_IDX_W-1:0] scr_sel;
  logic [DATA_W-1:0]       rd_val;
  logic                    rd_ok, wr_ok, err_c, wr_commit;
  logic                    unused_addr_lsb;

  logic [DATA_W-1:0]       scratch_q [NUM_SCRATCH];
  logic [DATA_W-1:0]       wr_count_q, wr_count_d;
  logic                    irq_en_q, irq_en_d;
  logic                    pend_q, pend_d;
  logic [STATUS_IDX_W-1:0] last_idx_q, last_idx_d;

  apb_wait_gen #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait_gen (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .ready   (ready)
  );

  assign unused_addr_lsb = ^PADDR[1:0];
  assign widx            = PADDR[APB_ADDR_WIDTH-1:2];

  // Address decode and read mux
  always_comb begin
    hit_sig    = (widx == IDX_W'(OFS_SIGNATURE >> 2));
    hit_cnt    = (widx == IDX_W'(OFS_WR_COUNT >> 2));
    hit_ctrl   = (widx == IDX_W'(OFS_CTRL >> 2));
    hit_status = (widx == IDX_W'(OFS_STATUS >> 2));
    hit_scr    = (widx >= IDX_W'(SCR_FIRST)) && (widx < IDX_W'(SCR_FIRST + NUM_SCRATCH));
    scr_sel    = STATUS_IDX_W'(widx - IDX_W'(SCR_FIRST));
    rd_val     = '0;
    rd_ok      = 1'b0;
    wr_ok      = 1'b0;
    if (hit_sig) begin
      rd_val = SIGNATURE;
      rd_ok  = 1'b1;
    end else if (hit_cnt) begin
      rd_val = wr_count_q;
      rd_ok  = 1'b1;
    end else if (hit_ctrl) begin
      rd_val[CTRL_IRQ_EN_BIT] = irq_en_q;
      rd_ok  = 1'b1;
      wr_ok  = 1'b1;
    end else if (hit_status) begin
      rd_val[STATUS_PEND_BIT] = pend_q;
      rd_val[STATUS_IDX_LSB +: STATUS_IDX_W] = last_idx_q;
      rd_ok  = 1'b1;
      wr_ok  = 1'b1;
    end else if (hit_scr) begin
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (scr_sel == STATUS_IDX_W'(i)) rd_val = scratch_q[i];
      end
      rd_ok  = 1'b1;
      wr_ok  = 1'b1;
    end
    err_c     = PWRITE ? ~wr_ok : ~rd_ok;
    wr_commit = ready & PWRITE & ~err_c;
  end

  assign PREADY  = ready;
  assign PSLVERR = ready & err_c;
  assign PRDATA  = (ready && !err_c && !PWRITE) ? rd_val : '0;

  // Control/status next state; a CLR write overrides its own increment
  always_comb begin
    wr_count_d = wr_count_q;
    irq_en_d   = irq_en_q;
    pend_d     = pend_q;
    last_idx_d = last_idx_q;
    if (wr_commit) begin
      wr_count_d = wr_count_q + 32'd1;
      if (hit_ctrl) begin
        irq_en_d = PWDATA[CTRL_IRQ_EN_BIT];
        if (PWDATA[CTRL_CLR_BIT]) wr_count_d = '0;
      end
      if (hit_status && PWDATA[STATUS_PEND_BIT]) pend_d = 1'b0;
      if (hit_scr) begin
        last_idx_d = scr_sel;
        if (irq_en_q) pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      wr_count_q <= '0;
      irq_en_q   <= 1'b0;
      pend_q     <= 1'b0;
      last_idx_q <= '0;
      irq_o      <= 1'b0;
      for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= '0;
    end else begin
      wr_count_q <= wr_count_d;
      irq_en_q   <= irq_en_d;
      pend_q     <= pend_d;
      last_idx_q <= last_idx_d;
      irq_o      <= pend_d & irq_en_d;
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (wr_commit && hit_scr && (scr_sel == STATUS_IDX_W'(i))) scratch_q[i] <= PWDATA;
      end
    end
  end

endmodule

// File: tb/tb_apb_dummy_regfile.sv
// Directed bench for apb_dummy_regfile: one instance with two wait states
// and one zero-wait instance sharing the bus except for their selects.
module tb_apb_dummy_regfile;

  localparam logic [31:0] SIG = 32'hC0DE_0001;

  logic        clk = 1'b0;
  logic        hresetn;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite, penable, psel2, psel0;
  logic [31:0] prdata2, prdata0;
  logic        pready2, pready0, pslverr2, pslverr0, irq2, irq0;

  int          asserts  = 0;
  int          failures = 0;
  logic [31:0] rd;
  logic        er;
  int          w;

  always #5 clk = ~clk;

  apb_dummy_regfile #(.WAIT_CYCLES(2)) dut2 (
    .HCLK(clk), .HRESETn(hresetn), .PADDR(paddr), .PWDATA(pwdata), .PWRITE(pwrite),
    .PSEL(psel2), .PENABLE(penable), .PRDATA(prdata2), .PREADY(pready2),
    .PSLVERR(pslverr2), .irq_o(irq2)
  );

  apb_dummy_regfile #(.WAIT_CYCLES(0)) dut0 (
    .HCLK(clk), .HRESETn(hresetn), .PADDR(paddr), .PWDATA(pwdata), .PWRITE(pwrite),
    .PSEL(psel0), .PENABLE(penable), .PRDATA(prdata0), .PREADY(pready0),
    .PSLVERR(pslverr0), .irq_o(irq0)
  );

  // Full APB transfer starting at a negedge; returns at the negedge after commit
  task automatic apb_xfer(input bit sel0, input logic [11:0] addr, input logic wr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic err, output int waits);
    bit done = 0;
    paddr = addr; pwrite = wr; pwdata = wdata; penable = 1'b0;
    if (sel0) psel0 = 1'b1; else psel2 = 1'b1;
    @(negedge clk);
    penable = 1'b1;
    waits = 0; rdata = '0; err = 1'b1;
    for (int k = 0; k < 16; k++) begin
      #1;
      if (sel0 ? pready0 : pready2) begin
        rdata = sel0 ? prdata0 : prdata2;
        err   = sel0 ? pslverr0 : pslverr2;
        done  = 1;
        break;
      end
      waits++;
      @(negedge clk);
    end
    asserts++;
    if (!done) begin failures++; $display("FAIL apb_timeout addr=%h no PREADY after 16 cycles", addr); end
    @(negedge clk);
    psel0 = 1'b0; psel2 = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    hresetn = 1'b0; psel2 = 1'b0; psel0 = 1'b0; penable = 1'b0;
    pwrite = 1'b0; paddr = '0; pwdata = '0;
    repeat (3) @(negedge clk);
    hresetn = 1'b1;
    #1;
    asserts++; if (pready2 !== 1'b0) begin failures++; $display("FAIL reset_pready got %b exp 0", pready2); end
    asserts++; if (prdata2 !== 32'h0) begin failures++; $display("FAIL reset_prdata got %h exp 0", prdata2); end
    asserts++; if (pslverr2 !== 1'b0) begin failures++; $display("FAIL reset_pslverr got %b exp 0", pslverr2); end
    asserts++; if (irq2 !== 1'b0 || irq0 !== 1'b0) begin failures++; $display("FAIL reset_irq got %b/%b exp 0/0", irq2, irq0); end
    @(negedge clk);
  endtask

  task automatic test_signature();
    apb_xfer(0, 12'h000, 1'b0, 32'h0, rd, er, w);
    asserts++; if (w !== 2) begin failures++; $display("FAIL sig_waits got %0d exp 2", w); end
    asserts++; if (rd !== SIG) begin failures++; $display("FAIL sig_read got %h exp %h", rd, SIG); end
    asserts++; if (er !== 1'b0) begin failures++; $display("FAIL sig_err got %b exp 0", er); end
  endtask

  task automatic test_scratch();
    apb_xfer(0, 12'h018, 1'b1, 32'hA5A5_A5A5, rd, er, w);
    asserts++; if (er !== 1'b0) begin failures++; $display("FAIL scr_wr_err got %b exp 0", er); end
    apb_xfer(0, 12'h018, 1'b0, 32'h0, rd, er, w);
    asserts++; if (rd !== 32'hA5A5_A5A5) begin failures++; $display("FAIL scr_read got %h exp a5a5a5a5", rd); end
    apb_xfer(0, 12'h004, 1'b0, 32'h0, rd, er, w);
    asserts++; if (rd !== 32'd1) begin failures++; $display("FAIL scr_wrcount got %h exp 1", rd); end
    apb_xfer(0, 12'h00C, 1'b0, 32'h0, rd, er, w);
    asserts++; if (rd !== 32'h20) begin failures++; $display("FAIL scr_status got %h exp 20", rd); end
  endtask

  task automatic test_errors();
    logic [11:0] bad [3] = '{12'h000, 12'h004, 12'h040};
    for (int i = 0; i < 3; i++) begin
      apb_xfer(0, bad[i], 1'b1, 32'h1234_5678, rd, er, w);
      asserts++; if (er !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL err_write addr=%h got err=%b data=%h exp err=1 data=0", bad[i], er, rd); end
    end
    apb_xfer(0, 12'h040, 1'b0, 32'h0, rd, er, w);
    asserts++; if (er !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL err_read got err=%b data=%h exp err=1 data=0", er, rd); end
    apb_xfer(0, 12'h004, 1'b0, 32'h0, rd, er, w);
    asserts++; if (rd !== 32'd1 || er !== 1'b0) begin failures++; $display("FAIL err_wrcount got %h err=%b exp 1 err=0", rd, er); end
    apb_xfer(0, 12'h000, 1'b0, 32'h0, rd, er, w);
    asserts++; if (rd !== SIG) begin failures++; $display("FAIL err_sig got %h exp %h", rd, SIG); end
  endtask

  task automatic test_irq();
    apb_xfer(0, 12'h008, 1'b1, 32'h2, rd, er, w);
    apb_xfer(0, 12'h010, 1'b1, 32'h0000_0011, rd, er, w);
    asserts++; if (irq2 !== 1'b1) begin failures++; $display("FAIL irq_set got %b exp 1", irq2); end
    apb_xfer(0, 12'h00C, 1'b0, 32'h0, rd, er, w);
    asserts++; if (rd !== 32'h01) begin failures++; $display("FAIL irq_status got %h exp 01", rd); end
    apb_xfer(0, 12'h00C, 1'b1, 32'h1, rd, er, w);
    asserts++; if (irq2 !== 1'b0) begin failures++; $display("FAIL irq_clear got %b exp 0", irq2); end
    apb_xfer(0, 12'h008, 1'b1, 32'h0, rd, er, w);
    apb_xfer(0, 12'h010, 1'b1, 32'h0000_0011, rd, er, w);
    asserts++; if (irq2 !== 1'b0) begin failures++; $display("FAIL irq_masked got %b exp 0", irq2); end
    apb_xfer(0, 12'h00C, 1'b0, 32'h0, rd, er, w);
    asserts++; if (rd !== 32'h00) begin failures++; $display("FAIL irq_nopend got %h exp 00", rd); end
  endtask

  task automatic test_clear();
    apb_xfer(0, 12'h014, 1'b1, 32'h1111_0001, rd, er, w);
    apb_xfer(0, 12'h018, 1'b1, 32'h2222_0002, rd, er, w);
    apb_xfer(0, 12'h01C, 1'b1, 32'h3333_0003, rd, er, w);
    apb_xfer(0, 12'h004, 1'b0, 32'h0, rd, er, w);
    asserts++; if (rd !== 32'd9) begin failures++; $display("FAIL clr_before got %0d exp 9", rd); end
    apb_xfer(0, 12'h00C, 1'b0, 32'h0, rd, er, w);
    asserts++; if (rd !== 32'h30) begin failures++; $display("FAIL clr_lastidx got %h exp 30", rd); end
    apb_xfer(0, 12'h008, 1'b1, 32'h1, rd, er, w);
    apb_xfer(0, 12'h004, 1'b0, 32'h0, rd, er, w);
    asserts++; if (rd !== 32'd0) begin failures++; $display("FAIL clr_after got %0d exp 0", rd); end
    apb_xfer(0, 12'h008, 1'b0, 32'h0, rd, er, w);
    asserts++; if (rd !== 32'h0) begin failures++; $display("FAIL clr_ctrl got %h exp 0", rd); end
  endtask

  task automatic test_reset_mid();
    paddr = 12'h014; pwrite = 1'b1; pwdata = 32'hDEAD_BEEF; penable = 1'b0; psel2 = 1'b1;
    @(negedge clk);
    penable = 1'b1;
    #1;
    asserts++; if (pready2 !== 1'b0 || prdata2 !== 32'h0) begin failures++; $display("FAIL mid_wait got ready=%b data=%h exp 0/0", pready2, prdata2); end
    hresetn = 1'b0;
    @(negedge clk);
    #1;
    asserts++; if (pready2 !== 1'b0) begin failures++; $display("FAIL mid_reset_ready got %b exp 0", pready2); end
    psel2 = 1'b0; penable = 1'b0;
    @(negedge clk);
    hresetn = 1'b1;
    apb_xfer(0, 12'h014, 1'b0, 32'h0, rd, er, w);
    asserts++; if (rd !== 32'h0) begin failures++; $display("FAIL mid_scratch got %h exp 0", rd); end
    apb_xfer(0, 12'h004, 1'b0, 32'h0, rd, er, w);
    asserts++; if (rd !== 32'h0) begin failures++; $display("FAIL mid_wrcount got %h exp 0", rd); end
  endtask

  task automatic test_zero_wait();
    apb_xfer(1, 12'h000, 1'b0, 32'h0, rd, er, w);
    asserts++; if (w !== 0) begin failures++; $display("FAIL zw_waits got %0d exp 0", w); end
    asserts++; if (rd !== SIG || er !== 1'b0) begin failures++; $display("FAIL zw_sig got %h err=%b exp %h err=0", rd, er, SIG); end
    apb_xfer(1, 12'h01C, 1'b1, 32'h5A5A_0F0F, rd, er, w);
    apb_xfer(1, 12'h01C, 1'b0, 32'h0, rd, er, w);
    asserts++; if (rd !== 32'h5A5A_0F0F) begin failures++; $display("FAIL zw_scratch got %h exp 5a5a0f0f", rd); end
    apb_xfer(1, 12'h004, 1'b0, 32'h0, rd, er, w);
    asserts++; if (rd !== 32'd1) begin failures++; $display("FAIL zw_wrcount got %h exp 1", rd); end
    apb_xfer(1, 12'h040, 1'b0, 32'h0, rd, er, w);
    asserts++; if (er !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL zw_err got err=%b data=%h exp 1/0", er, rd); end
  endtask

  initial begin
    test_reset();
    test_signature();
    test_scratch();
    test_errors();
    test_irq();
    test_clear();
    test_reset_mid();
    test_zero_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule

// File: doc/apb_dummy_regfile.md
Name: apb_dummy_regfile

Overview:
Parametrised APB teaching/test slave that generalises the single-signature and single-scratch dummy register block.
- Provides a read-only signature, a write counter, control and status registers, and NUM_SCRATCH R/W scratch words.
- Inserts configurable wait states and reports errors via PSLVERR.
- Raises a level interrupt on scratch writes.
- Sits on a 4KB APB peripheral slot of the SoC APB bus.

Parameters:
APB_ADDR_WIDTH, 12, APB address width (4KB slot).
NUM_SCRATCH, 4, number of 32-bit scratch registers; legal range 1..16.
WAIT_CYCLES, 2, wait states inserted per access; 0 means a zero-wait slave.
SIGNATURE, 32'hC0DE_0001, value returned by the SIGNATURE register.

Ports:
HCLK  input  1  clock.
HRESETn  input  1  reset, synchronous, active-low.
PADDR  input  APB_ADDR_WIDTH  byte address; bits [1:0] ignored.
PWDATA  input  32  write data.
PWRITE  input  1  1 = write, 0 = read.
PSEL  input  1  slave select.
PENABLE  input  1  access phase.
PRDATA  output  32  read data.
PREADY  output  1  transfer complete.
PSLVERR  output  1  transfer error, valid only with PREADY.
irq_o  output  1  level interrupt.

Behaviour:
Reset and clocking:
- One clock, HCLK. Reset is synchronous, active-low (HRESETn sampled on the HCLK rising edge).
- Reset values: all registers 0, wait FSM in IDLE, PRDATA=0, PREADY=0, PSLVERR=0, irq_o=0.

Register map (word index = PADDR[APB_ADDR_WIDTH-1:2]):
- 0x00 SIGNATURE: RO, reads SIGNATURE.
- 0x04 WR_COUNT: RO, 32-bit count of completed error-free writes.
- 0x08 CTRL: RW, bit0 CLR (self-clearing, reads 0), bit1 IRQ_EN; other bits read 0.
- 0x0C STATUS: bit0 PEND (RW1C), bits[7:4] index of the last scratch word written (RO).
- 0x10 + 4*i: SCRATCH[i], RW, for i = 0..NUM_SCRATCH-1.
- Any other offset is unmapped.

Wait FSM (states IDLE, ACCESS):
- IDLE -> ACCESS when PSEL=1 and PENABLE=1; the wait counter starts at 0.
- In ACCESS the counter increments each cycle.
- PREADY = PSEL & PENABLE & (cnt == WAIT_CYCLES). PREADY is combinational from the counter state.
- With WAIT_CYCLES=0, PREADY=1 in the first access cycle.
- On the PREADY cycle the FSM returns to IDLE. Back-to-back transfers restart the count.
- If PSEL drops mid-access (protocol violation), return to IDLE, clear the counter, and commit no effect.

Commit rules (only on the PREADY cycle):
- Error cases: writes to SIGNATURE, WR_COUNT or an unmapped offset, and reads of an unmapped offset.
  - Error cycle drives PSLVERR=1 and PRDATA=0.
  - No state change; WR_COUNT is not incremented.
- Valid read: PRDATA = register value, PSLVERR=0.
- PRDATA = 0 whenever PREADY=0.
- Valid write:
  - Update the target register and WR_COUNT += 1. WR_COUNT wraps 0xFFFF_FFFF -> 0.
  - Writing CTRL with CLR=1 sets WR_COUNT=0; the clear wins over that write's increment.
- Scratch write with IRQ_EN=1 sets PEND. Scratch writes with IRQ_EN=0 never set PEND.
- STATUS write with bit0=1 clears PEND. A set and a clear in the same cycle cannot occur because only one write commits per cycle.
- irq_o = PEND & IRQ_EN, registered. Clearing IRQ_EN masks irq_o but keeps PEND.

Reset mid-transfer: state returns to reset values the next edge; PREADY=0; the master must restart the transfer.

Decomposition:
- Package apb_dummy_pkg holds:
  - register offset localparams (OFS_SIGNATURE, OFS_WR_COUNT, OFS_CTRL, OFS_STATUS, OFS_SCRATCH_BASE);
  - CTRL/STATUS bit positions;
  - the wait_state_e enum {IDLE, ACCESS}.
- Sub-module apb_wait_gen, parameter WAIT_CYCLES: inputs HCLK, HRESETn, PSEL, PENABLE; output ready. It contains the FSM and counter; the counter width is max(1, $clog2(WAIT_CYCLES+1)).
- The top level holds the address decode, the register file and the IRQ logic.

Test Plan:
- Reset, then read 0x00 with WAIT_CYCLES=2 -> PREADY low for 2 access cycles, high on the 3rd; PRDATA=0xC0DE0001, PSLVERR=0.
- Write 0xA5A5A5A5 to 0x18 (SCRATCH[2]) then read 0x18 -> 0xA5A5A5A5; WR_COUNT reads 1; STATUS[7:4]=2.
- Write to 0x00, 0x04, 0x40 and read 0x40 -> each completes with PSLVERR=1 and PRDATA=0; WR_COUNT unchanged; SIGNATURE unchanged.
- Write CTRL=0x2, then write SCRATCH[0] -> irq_o=1 one cycle after the PREADY edge. Write STATUS=0x1 -> irq_o=0. Write CTRL=0x0 then SCRATCH[0] -> irq_o stays 0.
- Do 3 writes, then write CTRL=0x1 -> WR_COUNT=0; CTRL reads 0x0.
- Assert HRESETn=0 during the wait state of a scratch write -> PREADY=0, scratch remains 0, WR_COUNT=0. Also rerun the first test with WAIT_CYCLES=0 -> PREADY=1 in the first access cycle.
